// File: rtl/sierpinski_pkg.sv
// Shared definitions for the Sierpinski row sequencer: LFSR geometry, taps, FSM states and
// the LFSR next-state function.
package sierpinski_pkg;

    localparam int unsigned LFSR_W = 14;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 14'h0001;

    localparam int unsigned TAP_A = 13;
    localparam int unsigned TAP_B = 12;
    localparam int unsigned TAP_C = 11;
    localparam int unsigned TAP_D = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        WAIT,
        DONE
    } seq_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D]};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by the default seed.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? LFSR_SEED_DEFAULT : s;
    endfunction

endpackage

// File: rtl/sierpinski_row_sequencer_if.sv
// Row stream between the sequencer (master) and the display/output stage (slave).
interface sierpinski_row_sequencer_if #(
    parameter int unsigned ROW_W = 8
);

    logic [sierpinski_pkg::LFSR_W-1:0] row_data;
    logic                              row_valid;
    logic                              row_ready;
    logic                              row_last;
    logic [ROW_W-1:0]                  row_index;

    modport master (
        output row_data,
        output row_valid,
        output row_last,
        output row_index,
        input  row_ready
    );

    modport slave (
        input  row_data,
        input  row_valid,
        input  row_last,
        input  row_index,
        output row_ready
    );

endinterface

// File: rtl/sierpinski_lfsr_core.sv
// 14-bit Sierpinski LFSR register: synchronous load has priority over step; holds otherwise.
module sierpinski_lfsr_core
    import sierpinski_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] lfsr
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = load_val;
        end else if (step) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED_DEFAULT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/sierpinski_row_sequencer.sv
// Run controller for the Sierpinski LFSR: seeds it, paces rows over a valid/ready stream and
// signals completion.
module sierpinski_row_sequencer
    import sierpinski_pkg::*;
#(
    parameter int unsigned ROW_W = 8,
    parameter int unsigned DIV_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [LFSR_W-1:0]          seed,
    input  logic [ROW_W-1:0]           row_count,
    input  logic [DIV_W-1:0]           step_div,
    sierpinski_row_sequencer_if.master row_if,
    output logic                       busy,
    output logic                       done
);

    seq_state_e        state_q, state_d;
    logic [ROW_W-1:0]  row_index_q, row_index_d;
    logic [ROW_W-1:0]  count_q, count_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  divider_q, divider_d;
    logic [LFSR_W-1:0] seed_q, seed_d;

    logic              lfsr_load;
    logic              lfsr_step;
    logic [LFSR_W-1:0] lfsr;
    logic              is_last;
    logic              handshake;
    logic              run_active;

    assign is_last    = (row_index_q == (count_q - ROW_W'(1)));
    assign handshake  = (state_q == STREAM) && row_if.row_ready;
    assign run_active = (state_q == LOAD) || (state_q == STREAM) || (state_q == WAIT);

    always_comb begin
        state_d     = state_q;
        row_index_d = row_index_q;
        count_d     = count_q;
        div_d       = div_q;
        divider_d   = divider_q;
        seed_d      = seed_q;
        lfsr_load   = 1'b0;
        lfsr_step   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    seed_d  = seed_fix(seed);
                    count_d = row_count;
                    div_d   = (step_div == '0) ? DIV_W'(1) : step_div;
                    state_d = (row_count == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                lfsr_load   = 1'b1;
                row_index_d = '0;
                divider_d   = '0;
                state_d     = STREAM;
            end
            STREAM: begin
                if (handshake) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        lfsr_step   = 1'b1;
                        row_index_d = row_index_q + ROW_W'(1);
                        divider_d   = div_q - DIV_W'(1);
                        state_d     = (div_q == DIV_W'(1)) ? STREAM : WAIT;
                    end
                end
            end
            WAIT: begin
                // Leaving on the cycle the divider expires gives exactly div cycles between beats.
                divider_d = divider_q - DIV_W'(1);
                if (divider_q <= DIV_W'(1)) begin
                    state_d = STREAM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything in a busy state and discards the in-flight row.
        if (abort && run_active) begin
            state_d     = IDLE;
            lfsr_load   = 1'b0;
            lfsr_step   = 1'b0;
            row_index_d = row_index_q;
            divider_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_index_q <= '0;
            count_q     <= '0;
            div_q       <= '0;
            divider_q   <= '0;
            seed_q      <= LFSR_SEED_DEFAULT;
        end else begin
            state_q     <= state_d;
            row_index_q <= row_index_d;
            count_q     <= count_d;
            div_q       <= div_d;
            divider_q   <= divider_d;
            seed_q      <= seed_d;
        end
    end

    sierpinski_lfsr_core u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (lfsr_load),
        .load_val (seed_q),
        .step     (lfsr_step),
        .lfsr     (lfsr)
    );

    assign row_if.row_data  = lfsr;
    assign row_if.row_valid = (state_q == STREAM);
    assign row_if.row_last  = (state_q == STREAM) && is_last;
    assign row_if.row_index = row_index_q;
    assign busy             = run_active;
    assign done             = (state_q == DONE);

    a_stall_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        (row_if.row_valid && !row_if.row_ready && !abort)
            |=> ($stable(row_if.row_data) && $stable(row_if.row_index) && row_if.row_valid)
    );

    a_index_bounded: assert property (
        @(posedge clk) disable iff (!rst_n)
        row_if.row_valid |-> (row_if.row_index < count_q)
    );

endmodule

// File: tb/tb_sierpinski_row_sequencer.sv
// Bench for sierpinski_row_sequencer: cycle-stamped run model checked every cycle, plus
// hand-computed row sequences and run lengths.
module tb_sierpinski_row_sequencer;

    localparam int unsigned ROW_W = 8;
    localparam int unsigned DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [13:0]      seed = '0;
    logic [ROW_W-1:0] row_count = '0;
    logic [DIV_W-1:0] step_div = '0;
    logic             busy;
    logic             done;

    sierpinski_row_sequencer_if #(.ROW_W(ROW_W)) rif ();

    sierpinski_row_sequencer #(.ROW_W(ROW_W), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .seed      (seed),
        .row_count (row_count),
        .step_div  (step_div),
        .row_if    (rif),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] step14(input logic [13:0] v);
        logic fb;
        fb = v[13] ^ v[12] ^ v[11] ^ v[1];
        return {v[12:0], fb};
    endfunction

    // Run model: which cycle each row may appear, which row is owed, when done pulses.
    bit          m_run = 1'b0;
    int          m_idx = 0;
    int          m_cnt = 0;
    int          m_div = 1;
    int          m_next = 0;
    int          m_done_cyc = -1;
    logic [13:0] m_lfsr = 14'h0001;
    logic [13:0] seen[$];
    int          n_done = 0;

    always @(negedge clk) begin
        bit exp_valid;
        if (!rst_n) begin
            m_run      = 1'b0;
            m_done_cyc = -1;
            check("rst_valid", 32'(rif.row_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_done", 32'(done), 0);
            check("rst_data", 32'(rif.row_data), 32'h0001);
            check("rst_index", 32'(rif.row_index), 0);
            check("rst_last", 32'(rif.row_last), 0);
        end else begin
            exp_valid = m_run && (cyc >= m_next);
            check("valid", 32'(rif.row_valid), 32'(exp_valid));
            check("busy", 32'(busy), 32'(m_run));
            check("done", 32'(done), 32'(cyc == m_done_cyc));
            if (done) n_done++;
            if (exp_valid) begin
                check("data", 32'(rif.row_data), 32'(m_lfsr));
                check("index", 32'(rif.row_index), 32'(m_idx));
                check("last", 32'(rif.row_last), 32'(m_idx == m_cnt - 1));
            end
            if (m_run && abort) begin
                m_run = 1'b0;
            end else if (exp_valid && rif.row_ready) begin
                seen.push_back(rif.row_data);
                if (m_idx == m_cnt - 1) begin
                    m_run      = 1'b0;
                    m_done_cyc = cyc + 1;
                end else begin
                    m_idx++;
                    m_lfsr = step14(m_lfsr);
                    m_next = cyc + m_div;
                end
            end else if (!m_run && cyc != m_done_cyc && start && !abort) begin
                if (row_count == 0) begin
                    m_done_cyc = cyc + 1;
                end else begin
                    m_run  = 1'b1;
                    m_idx  = 0;
                    m_cnt  = int'(row_count);
                    m_div  = (step_div == 0) ? 1 : int'(step_div);
                    m_lfsr = (seed == 0) ? 14'h0001 : seed;
                    m_next = cyc + 2;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are scrambled after the start cycle; a correct DUT ignores them mid-run.
    task automatic pulse_start(input logic [13:0] s, input logic [ROW_W-1:0] c,
                               input logic [DIV_W-1:0] d);
        seed      = s;
        row_count = c;
        step_div  = d;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        seed      = 14'h2AAA;
        row_count = 8'hFF;
        step_div  = 8'h07;
    endtask

    task automatic wait_done(input string name, input int budget, output int at_cyc);
        bit got;
        got    = 1'b0;
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got    = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
        check(name, 32'(got), 1);
        tick();
    endtask

    task automatic wait_idx(input string name, input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (m_run && m_idx >= target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check(name, 32'(ok), 1);
    endtask

    task automatic chk_rows(input string name, input int num, input logic [13:0] e0,
                            input logic [13:0] e1, input logic [13:0] e2, input logic [13:0] e3);
        logic [13:0] e[4];
        e = '{e0, e1, e2, e3};
        check({name, "_nrows"}, 32'(seen.size()), 32'(num));
        for (int i = 0; i < num; i++) begin
            check({name, "_row"}, (i < seen.size()) ? 32'(seen[i]) : 32'hDEAD, 32'(e[i]));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int at;
        int nd0;
        rif.row_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        rif.row_ready = 1'b1;

        // Basic back-to-back run; done 6 cycles after the start cycle.
        seen.delete(); nd0 = n_done; c0 = cyc;
        pulse_start(14'h0001, 8'd4, 8'd1);
        wait_done("t1_done", 40, at);
        check("t1_len", 32'(at - c0), 6);
        chk_rows("t1", 4, 14'h0001, 14'h0002, 14'h0005, 14'h000A);
        check("t1_ndone", 32'(n_done - nd0), 1);

        // Zero seed and zero divider are both substituted.
        seen.delete();
        pulse_start(14'h0000, 8'd2, 8'd0);
        wait_done("t2_done", 40, at);
        chk_rows("t2", 2, 14'h0001, 14'h0002, 14'h0, 14'h0);

        // Paced rows: 4 cycles between handshakes.
        seen.delete(); c0 = cyc;
        pulse_start(14'h0001, 8'd3, 8'd4);
        wait_done("t3_done", 60, at);
        check("t3_len", 32'(at - c0), 11);
        chk_rows("t3", 3, 14'h0001, 14'h0002, 14'h0005, 14'h0);

        // Back-pressure on row 1 for 5 cycles.
        seen.delete();
        pulse_start(14'h0001, 8'd3, 8'd1);
        wait_idx("t4_reach", 1, 20);
        rif.row_ready = 1'b0;
        repeat (5) tick();
        check("t4_hold_data", 32'(rif.row_data), 32'h0002);
        check("t4_hold_index", 32'(rif.row_index), 1);
        check("t4_hold_valid", 32'(rif.row_valid), 1);
        check("t4_hold_last", 32'(rif.row_last), 0);
        rif.row_ready = 1'b1;
        wait_done("t4_done", 40, at);
        chk_rows("t4", 3, 14'h0001, 14'h0002, 14'h0005, 14'h0);

        // Abort while waiting for row 2, then abort+start together, then a fresh run.
        seen.delete(); nd0 = n_done;
        pulse_start(14'h0001, 8'd8, 8'd4);
        wait_idx("t5_reach", 2, 40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy", 32'(busy), 0);
        check("t5_valid", 32'(rif.row_valid), 0);
        repeat (10) tick();
        check("t5_nodone", 32'(n_done - nd0), 0);
        abort = 1'b1; start = 1'b1; row_count = 8'd3; seed = 14'h0001;
        tick();
        abort = 1'b0; start = 1'b0;
        tick();
        check("t5_abort_beats_start", 32'(busy), 0);
        seen.delete();
        pulse_start(14'h00A5, 8'd2, 8'd1);
        wait_done("t5_restart_done", 40, at);
        chk_rows("t5", 2, 14'h00A5, 14'h014A, 14'h0, 14'h0);

        // Zero-row run: done the cycle after start, no rows.
        seen.delete(); c0 = cyc;
        pulse_start(14'h0005, 8'd0, 8'd3);
        wait_done("t6_done", 10, at);
        check("t6_len", 32'(at - c0), 1);
        check("t6_nrows", 32'(seen.size()), 0);

        // Start during a run is ignored.
        seen.delete(); nd0 = n_done;
        pulse_start(14'h0001, 8'd3, 8'd2);
        tick();
        pulse_start(14'h1234, 8'd5, 8'd1);
        wait_done("t7_done", 60, at);
        chk_rows("t7", 3, 14'h0001, 14'h0002, 14'h0005, 14'h0);
        repeat (3) tick();
        check("t7_ndone", 32'(n_done - nd0), 1);

        // Asynchronous reset mid-stream.
        nd0 = n_done;
        pulse_start(14'h0001, 8'd8, 8'd1);
        wait_idx("t8_reach", 3, 20);
        rst_n = 1'b0;
        #1;
        check("t8_valid", 32'(rif.row_valid), 0);
        check("t8_busy", 32'(busy), 0);
        check("t8_data", 32'(rif.row_data), 32'h0001);
        check("t8_index", 32'(rif.row_index), 0);
        check("t8_last", 32'(rif.row_last), 0);
        check("t8_done", 32'(done), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("t8_nodone", 32'(n_done - nd0), 0);
        seen.delete();
        pulse_start(14'h0001, 8'd2, 8'd1);
        wait_done("t8_after_done", 40, at);
        chk_rows("t8", 2, 14'h0001, 14'h0002, 14'h0, 14'h0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
